cp0_interrupt: RTL

Coprocessor-0 exception/interrupt responder for the 5-stage MIPS pipeline. It decodes the `oper` code issued by the pipeline controller for the instruction in ID, holds STATUS/CAUSE/EPC/EBASE, and latches external interrupt requests. It drives `jump_en`/`jump_addr` back to the controller and PC logic to redirect fetch to the handler on interrupt entry and to EPC on ERET.

---
 rtl/cp0_interrupt_pkg.sv | 27 ++
 rtl/cp0_interrupt_regs.sv | 95 +++++++++
 rtl/cp0_interrupt.sv | 94 +++++++++
 3 files changed

// File: rtl/cp0_interrupt_pkg.sv
// Shared CP0 encodings: operation codes, register numbers, bit positions and FSM states.
// The pipeline controller imports this package for the oper field as well.
package cp0_interrupt_pkg;

  typedef enum logic [1:0] {
    CP0_NOP  = 2'b00,
    CP0_MFC0 = 2'b01,
    CP0_MTC0 = 2'b10,
    CP0_ERET = 2'b11
  } cp0_oper_e;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_TRAP = 2'b01,
    S_ERET = 2'b10
  } cp0_state_e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_EBASE  = 5'd15;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_IP  = 10;

endpackage

// File: rtl/cp0_interrupt_regs.sv
// CP0 register file (STATUS/CAUSE/EPC/EBASE) with write decode and combinational read mux.
// Trap entry and ERET side effects are applied here on request from the control FSM.
module cp0_interrupt_regs
  import cp0_interrupt_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_w_i,
  input  logic        trap_i,
  input  logic [31:0] trap_epc_i,
  input  logic        eret_i,
  input  logic        ip_set_i,
  output logic [31:0] data_r_o,
  output logic        ie_o,
  output logic        exl_o,
  output logic        ip_o,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o
);

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic        ip_q, ip_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ebase_q, ebase_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      ip_q    <= 1'b0;
      epc_q   <= '0;
      ebase_q <= {EXC_VECTOR[31:2], 2'b00};
    end else begin
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      ip_q    <= ip_d;
      epc_q   <= epc_d;
      ebase_q <= ebase_d;
    end
  end

  always_comb begin
    ie_d    = ie_q;
    exl_d   = exl_q;
    ip_d    = ip_q;
    epc_d   = epc_q;
    ebase_d = ebase_q;
    if (trap_i) begin
      exl_d = 1'b1;
      ip_d  = 1'b0;
      epc_d = trap_epc_i;
    end else if (eret_i) begin
      exl_d = 1'b0;
    end else if (wr_en_i) begin
      case (addr_i)
        CP0_STATUS: begin
          ie_d  = data_w_i[ST_IE];
          exl_d = data_w_i[ST_EXL];
        end
        CP0_CAUSE: ip_d    = data_w_i[CA_IP];
        CP0_EPC:   epc_d   = data_w_i;
        CP0_EBASE: ebase_d = {data_w_i[31:2], 2'b00};
        default:   ;
      endcase
    end
    // A new request edge beats any clear (trap entry or MTC0) on the same edge
    if (ip_set_i) ip_d = 1'b1;
  end

  always_comb begin
    data_r_o = '0;
    case (addr_i)
      CP0_STATUS: begin
        data_r_o[ST_IE]  = ie_q;
        data_r_o[ST_EXL] = exl_q;
      end
      CP0_CAUSE: data_r_o[CA_IP] = ip_q;
      CP0_EPC:   data_r_o = epc_q;
      CP0_EBASE: data_r_o = ebase_q;
      default:   data_r_o = '0;
    endcase
  end

  assign ie_o    = ie_q;
  assign exl_o   = exl_q;
  assign ip_o    = ip_q;
  assign epc_o   = epc_q;
  assign ebase_o = ebase_q;

endmodule

// File: rtl/cp0_interrupt.sv
// CP0 interrupt/exception responder: edge-detects the external request, runs the
// RUN/TRAP/ERET redirect FSM and drives the fetch redirect back to the pipeline.
module cp0_interrupt
  import cp0_interrupt_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  oper_i,
  input  logic        en_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_w_i,
  output logic [31:0] data_r_o,
  input  logic        ir_in_i,
  input  logic [31:0] ret_addr_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o
);

  cp0_state_e  state_q, state_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic        ir_prev_q;

  logic        ie, exl, ip;
  logic [31:0] epc, ebase;
  logic        ip_set, in_run, take_trap, do_eret, wr_en;

  assign ip_set = ir_in_i & ~ir_prev_q;
  assign in_run = (state_q == S_RUN);

  // Interrupt entry has priority and suppresses the ID instruction's own operation
  assign take_trap = in_run & en_i & ip & ie & ~exl;
  assign do_eret   = in_run & en_i & ~take_trap & (oper_i == CP0_ERET) & exl;
  assign wr_en     = in_run & en_i & ~take_trap & (oper_i == CP0_MTC0);

  cp0_interrupt_regs #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .addr_i    (addr_i),
    .data_w_i  (data_w_i),
    .trap_i    (take_trap),
    .trap_epc_i(ret_addr_i),
    .eret_i    (do_eret),
    .ip_set_i  (ip_set),
    .data_r_o  (data_r_o),
    .ie_o      (ie),
    .exl_o     (exl),
    .ip_o      (ip),
    .epc_o     (epc),
    .ebase_o   (ebase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      jump_addr_q <= '0;
      ir_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      jump_addr_q <= jump_addr_d;
      ir_prev_q   <= ir_in_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    jump_addr_d = jump_addr_q;
    case (state_q)
      S_RUN: begin
        if (take_trap) begin
          state_d     = S_TRAP;
          jump_addr_d = ebase;
        end else if (do_eret) begin
          state_d     = S_ERET;
          jump_addr_d = epc;
        end
      end
      S_TRAP, S_ERET: begin
        if (en_i) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    jump_en_o   = (state_q != S_RUN);
    jump_addr_o = jump_addr_q;
  end

endmodule
